// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - handshake and result bundle for serial_subtractor
// Optional overflow flag V is present when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             READY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Z;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             V;

    modport master (
        output START, A, B, Bin,
        input  READY, DONE, D, Bout, Z, V
    );

    modport slave (
        input  START, A, B, Bin,
        output READY, DONE, D, Bout, Z, V
    );
`else
    modport master (
        output START, A, B, Bin,
        input  READY, DONE, D, Bout, Z
    );

    modport slave (
        input  START, A, B, Bin,
        output READY, DONE, D, Bout, Z
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the two's-complement overflow flag V.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    serial_subtractor_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;
    logic             z_reg;

    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell for the current bit plus acceptance/finish decodes
    always_comb begin
        d_bit    = sa[0] ^ sb[0] ^ br;
        br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_next = {d_bit, res[WIDTH-1:1]};
        accept   = bus.START && ((state == S_IDLE) || (state == S_FIN));
        last_bit = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
    end

    // Control FSM: IDLE/FIN accept a new operation, RUN spends exactly WIDTH edges
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (accept) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        state <= S_FIN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Operand shift registers, borrow chain and partial result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sa  <= '0;
            sb  <= '0;
            br  <= 1'b0;
            res <= '0;
        end else if (accept) begin
            sa  <= bus.A;
            sb  <= bus.B;
            br  <= bus.Bin;
        end else if (state == S_RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            br  <= br_next;
            res <= res_next;
        end
    end

    // Visible results update only on the edge that enters FIN, then hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_reg    <= '0;
            bout_reg <= 1'b0;
            z_reg    <= 1'b0;
        end else if (last_bit) begin
            d_reg    <= res_next;
            bout_reg <= br_next;
            z_reg    <= (res_next == '0);
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_sign;
    logic b_sign;
    logic v_reg;

    // Operand sign bits are kept so overflow can be judged once the result MSB appears
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
        end else if (accept) begin
            a_sign <= bus.A[WIDTH-1];
            b_sign <= bus.B[WIDTH-1];
        end
    end

    // Overflow: operand signs differ and result sign differs from the minuend; Bin ignored here
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v_reg <= 1'b0;
        end else if (last_bit) begin
            v_reg <= (a_sign != b_sign) && (d_bit != a_sign);
        end
    end

    assign bus.V = v_reg;
`endif

    assign bus.READY = (state == S_IDLE) || (state == S_FIN);
    assign bus.DONE  = (state == S_FIN);
    assign bus.D     = d_reg;
    assign bus.Bout  = bout_reg;
    assign bus.Z     = z_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one operation and check latency, READY-low duration, results and the one-cycle DONE
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] exp_d, input logic exp_bout, input logic exp_z,
                          input logic exp_v);
        int n;
        int ready_low;
        bit seen;
        n = 0;
        ready_low = 0;
        seen = 0;
        bus.START = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.Bin = bin;
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick();
            bus.START = 1'b0;
            n = i;
            if (bus.READY === 1'b0) ready_low++;
            if (bus.DONE === 1'b1) seen = 1;
        end
        if (!seen) n = 99;
        check({tag, " latency"}, n, 9);
        check({tag, " ready_low"}, ready_low, 8);
        check({tag, " D"}, bus.D, exp_d);
        check({tag, " Bout"}, bus.Bout, exp_bout);
        check({tag, " Z"}, bus.Z, exp_z);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check({tag, " V"}, bus.V, exp_v);
`else
        if (exp_v !== 1'b0 && exp_v !== 1'b1) $display("note: %s", tag);
`endif
        tick();
        check({tag, " done_pulse"}, bus.DONE, 1'b0);
        check({tag, " hold_D"}, bus.D, exp_d);
    endtask

    initial begin
        int first_done;
        int second_done;
        int dones;
        checks = 0;
        errors = 0;
        RST_N = 1'b0;
        bus.START = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;
        #12;
        check("rst READY", bus.READY, 1'b1);
        check("rst DONE", bus.DONE, 1'b0);
        check("rst D", bus.D, 8'h00);
        check("rst Bout", bus.Bout, 1'b0);
        check("rst Z", bus.Z, 1'b0);
        tick();
        RST_N = 1'b1;
        tick();

        // Basic subtraction and wrap/borrow cases
        run_op("t1 05-03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        run_op("t2 03-05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op("t2 10-0F-1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

        // Back-to-back with START held, operands disturbed mid-RUN
        first_done = -1;
        second_done = -1;
        bus.START = 1'b1;
        bus.A = 8'h20;
        bus.B = 8'h01;
        bus.Bin = 1'b0;
        for (int i = 1; i <= 30 && second_done < 0; i++) begin
            tick();
            if (i == 3 || i == 12) begin
                bus.A = 8'hFF;
                bus.B = 8'hFF;
            end
            if (i == 6 || i == 15) begin
                bus.A = 8'h20;
                bus.B = 8'h01;
            end
            if (bus.DONE === 1'b1) begin
                if (first_done < 0) begin
                    first_done = i;
                    check("t3 first D", bus.D, 8'h1F);
                end else begin
                    second_done = i;
                    check("t3 second D", bus.D, 8'h1F);
                    check("t3 second Bout", bus.Bout, 1'b0);
                    bus.START = 1'b0;
                end
            end
        end
        bus.START = 1'b0;
        check("t3 first latency", first_done, 9);
        check("t3 spacing", second_done - first_done, 9);
        tick();
        check("t3 idle READY", bus.READY, 1'b1);
        check("t3 idle DONE", bus.DONE, 1'b0);

        // START and operand changes during RUN are ignored; D holds until FIN
        bus.START = 1'b1;
        bus.A = 8'h50;
        bus.B = 8'h10;
        bus.Bin = 1'b0;
        first_done = -1;
        for (int i = 1; i <= 20 && first_done < 0; i++) begin
            tick();
            bus.START = 1'b0;
            if (i == 2) begin
                bus.START = 1'b1;
                bus.A = 8'hFF;
                bus.B = 8'h00;
                bus.Bin = 1'b1;
            end
            if (i == 4) check("t4 D hold in RUN", bus.D, 8'h1F);
            if (bus.DONE === 1'b1) first_done = i;
        end
        check("t4 latency", first_done, 9);
        check("t4 D", bus.D, 8'h40);
        check("t4 Z", bus.Z, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.DONE === 1'b1) dones++;
        end
        check("t4 no extra DONE", dones, 0);

        // Reset mid-RUN aborts with no DONE
        bus.START = 1'b1;
        bus.A = 8'h33;
        bus.B = 8'h11;
        bus.Bin = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            bus.START = 1'b0;
        end
        #2;
        RST_N = 1'b0;
        #1;
        check("t5 rst READY", bus.READY, 1'b1);
        check("t5 rst DONE", bus.DONE, 1'b0);
        check("t5 rst D", bus.D, 8'h00);
        tick();
        RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.DONE === 1'b1) dones++;
        end
        check("t5 no DONE after abort", dones, 0);
        run_op("t5 00-00-1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Signed overflow cases (V checked only when the feature is built in)
        run_op("t6 80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        run_op("t6 7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
        run_op("t6 05-03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
